// File: rtl/sram_bus_rr.sv
// sram_bus_rr: shares one synchronous single-port memory between a
// priority SPI write path and OUTPUT_COUNT round-robin read channels.
// Writes always take the port one cycle after their strobe; reads go
// through IDLE -> ISSUE -> WAIT (READ_LATENCY cycles) -> FINISH.
module sram_bus_rr #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int OUTPUT_COUNT      = 10,
  parameter int READ_LATENCY      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [ADDRESS_BUS_WIDTH-1:0]              write_address,
  input  logic [DATA_BUS_WIDTH-1:0]                 write_data,
  input  logic                                      write_strobe,
  input  logic [OUTPUT_COUNT-1:0]                   read_requests,
  input  logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0] read_addresses,
  output logic [DATA_BUS_WIDTH-1:0]                 read_data,
  output logic [OUTPUT_COUNT-1:0]                   read_finished_strobes,
  output logic [ADDRESS_BUS_WIDTH-1:0]              mem_address,
  output logic [DATA_BUS_WIDTH-1:0]                 mem_data_in,
  output logic                                      mem_write_enable,
  input  logic [DATA_BUS_WIDTH-1:0]                 mem_data_out,
  output logic [2:0]                                state
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int DW = DATA_BUS_WIDTH;
  localparam int GW = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;

  localparam logic [GW-1:0] LAST_CH  = GW'(OUTPUT_COUNT - 1);
  localparam logic [2:0]    LAT_LOAD = 3'(READ_LATENCY - 1);

  // Registered state
  logic [2:0]    state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] last_grant_reg, last_grant_next;
  logic [2:0]    lat_cnt_reg, lat_cnt_next;
  logic [DW-1:0] read_data_reg, read_data_next;
  logic          wr_pending_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [DW-1:0] wr_data_reg;
  logic [AW-1:0] mem_addr_hold_reg;

  // Arbitration helpers
  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic [GW:0]   cand;
  logic          rd_issue;
  logic [AW-1:0] rd_addr_arr [OUTPUT_COUNT];

  // Unflatten per-channel addresses and decode the finish pulse per channel
  generate
    for (genvar gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_chan
      assign rd_addr_arr[gi]           = read_addresses[gi*AW +: AW];
      assign read_finished_strobes[gi] = (state_reg == S_FINISH) &&
                                         (grant_reg == GW'(gi));
    end
  endgenerate

  // A read may use the port only when no write is issuing this cycle
  assign rd_issue = (state_reg == S_ISSUE) && !wr_pending_reg;

  assign mem_write_enable = wr_pending_reg;
  assign mem_data_in      = wr_data_reg;
  assign mem_address      = wr_pending_reg ? wr_addr_reg :
                            rd_issue       ? rd_addr_arr[grant_reg] :
                                             mem_addr_hold_reg;
  assign read_data        = read_data_reg;
  assign state            = state_reg;

  // Round-robin pick: first requester after last_grant, wrapping; the
  // loop runs from farthest to nearest so the nearest candidate wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = OUTPUT_COUNT; k >= 1; k--) begin
      cand = {1'b0, last_grant_reg} + (GW+1)'(k);
      if (cand >= (GW+1)'(OUTPUT_COUNT)) begin
        cand = cand - (GW+1)'(OUTPUT_COUNT);
      end
      if (read_requests[cand[GW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  // Read FSM next-state logic
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    lat_cnt_next    = lat_cnt_reg;
    read_data_next  = read_data_reg;
    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          grant_next      = pick_idx;
          last_grant_next = pick_idx;
          state_next      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rd_issue) begin
          lat_cnt_next = LAT_LOAD;
          state_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_reg == 3'd0) begin
          read_data_next = mem_data_out;
          state_next     = S_FINISH;
        end else begin
          lat_cnt_next = lat_cnt_reg - 3'd1;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM and read data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= LAST_CH;
      lat_cnt_reg    <= '0;
      read_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      lat_cnt_reg    <= lat_cnt_next;
      read_data_reg  <= read_data_next;
    end
  end

  // Capture each write strobe so it issues exactly one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pending_reg <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      wr_pending_reg <= write_strobe;
      if (write_strobe) begin
        wr_addr_reg <= write_address;
        wr_data_reg <= write_data;
      end
    end
  end

  // Remember the last driven address so the bus holds it when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_hold_reg <= '0;
    end else begin
      mem_addr_hold_reg <= mem_address;
    end
  end

endmodule

// File: tb/tb_sram_bus_rr.sv
// Randomised scoreboard bench for sram_bus_rr: a transaction-level model
// predicts write slots, read issue cycles, grant order and strobe times;
// a monitor compares the memory port and read completions every cycle.
module tb_sram_bus_rr;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int N   = 10;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     write_address;
  logic [DW-1:0]     write_data;
  logic              write_strobe;
  logic [N-1:0]      read_requests;
  logic [N*AW-1:0]   read_addresses;
  logic [DW-1:0]     read_data;
  logic [N-1:0]      read_finished_strobes;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data_in;
  logic              mem_write_enable;
  logic [DW-1:0]     mem_data_out;
  logic [2:0]        state;

  always #5 clk = ~clk;

  sram_bus_rr #(
    .ADDRESS_BUS_WIDTH(AW),
    .DATA_BUS_WIDTH(DW),
    .OUTPUT_COUNT(N),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .write_address(write_address),
    .write_data(write_data),
    .write_strobe(write_strobe),
    .read_requests(read_requests),
    .read_addresses(read_addresses),
    .read_data(read_data),
    .read_finished_strobes(read_finished_strobes),
    .mem_address(mem_address),
    .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out),
    .state(state)
  );

  // Memory content seen by reads is a fixed function of the address
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    logic [31:0] p;
    p = (32'(a) * 32'h0000_9E37) ^ 32'h0000_5A5A;
    return p[DW-1:0];
  endfunction

  // Synchronous memory with LAT cycles from address to data
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= rom(mem_address);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data_out = pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } is_t;
  typedef struct { int cyc; int ch; logic [DW-1:0] data; } rd_t;
  wr_t wq[$];
  is_t iq[$];
  rd_t rq[$];

  // Reference model: transaction timing from the bus rules
  int            m_last_ch = N - 1;
  bit            m_granted = 1'b0;
  int            m_earliest = 0;
  int            m_free_at = 0;
  int            m_ch = 0;
  logic [AW-1:0] m_addr;
  bit            m_wr_now;

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      wq.delete(); iq.delete(); rq.delete();
      m_granted = 1'b0;
      m_last_ch = N - 1;
      m_free_at = cyc + 1;
    end else begin
      m_wr_now = (wq.size() > 0) && (wq[0].cyc == cyc);
      if (!m_granted) begin
        if (cyc >= m_free_at && read_requests != '0) begin
          m_ch       = rr_pick(m_last_ch, read_requests);
          m_last_ch  = m_ch;
          m_addr     = read_addresses[m_ch*AW +: AW];
          m_granted  = 1'b1;
          m_earliest = cyc + 1;
        end
      end else if (cyc >= m_earliest && !m_wr_now) begin
        iq.push_back('{cyc, m_addr});
        rq.push_back('{cyc + LAT + 1, m_ch, rom(m_addr)});
        m_granted = 1'b0;
        m_free_at = cyc + LAT + 2;
      end
      if (write_strobe) wq.push_back('{cyc + 1, write_address, write_data});
    end
  end

  // Monitor: memory port and read completions, checked each cycle
  logic [AW-1:0] mon_last_addr = '0;
  logic [DW-1:0] mon_rd_hold = '0;
  logic [N-1:0]  exp_oh;
  bit            served [N];
  wr_t           w;
  is_t           is;
  rd_t           r;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("rst_we", 32'(mem_write_enable), 32'd0);
      chk("rst_addr", 32'(mem_address), 32'd0);
      chk("rst_wdata", 32'(mem_data_in), 32'd0);
      chk("rst_rdata", 32'(read_data), 32'd0);
      chk("rst_strobes", 32'(read_finished_strobes), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      mon_last_addr = '0;
      mon_rd_hold   = '0;
    end else begin
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w = wq.pop_front();
        chk("wr_we", 32'(mem_write_enable), 32'd1);
        chk("wr_addr", 32'(mem_address), 32'(w.addr));
        chk("wr_data", 32'(mem_data_in), 32'(w.data));
        mon_last_addr = w.addr;
        $display("write addr=%h data=%h cyc=%0d", w.addr, w.data, cyc);
      end else begin
        chk("idle_we", 32'(mem_write_enable), 32'd0);
        if (iq.size() > 0 && iq[0].cyc == cyc) begin
          is = iq.pop_front();
          chk("issue_addr", 32'(mem_address), 32'(is.addr));
          mon_last_addr = is.addr;
        end else begin
          chk("hold_addr", 32'(mem_address), 32'(mon_last_addr));
        end
      end
      if (read_finished_strobes != '0) begin
        for (int i = 0; i < N; i++) if (read_finished_strobes[i]) served[i] = 1'b1;
        if (rq.size() == 0) begin
          chk("spurious_strobe", 32'(read_finished_strobes), 32'd0);
        end else begin
          r = rq.pop_front();
          exp_oh = '0;
          exp_oh[r.ch] = 1'b1;
          chk("strobe_ch", 32'(read_finished_strobes), 32'(exp_oh));
          chk("read_data", 32'(read_data), 32'(r.data));
          chk("strobe_cyc", 32'(cyc), 32'(r.cyc));
          mon_rd_hold = r.data;
          $display("read  ch=%0d data=%h cyc=%0d", r.ch, read_data, cyc);
        end
      end else begin
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          r = rq.pop_front();
          chk("strobe_missing", 32'(read_finished_strobes), 32'(1 << r.ch));
        end
        chk("rdata_hold", 32'(read_data), 32'(mon_rd_hold));
      end
    end
  end

  // Stimulus: random requesters obeying the hold-until-strobe protocol
  int rst_cnt = 0;

  task automatic run(input int cycles, input int req_pct, input int wr_pct, input int rst_pct);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_n = 1'b1;
      end else if (rst_pct > 0 && $urandom_range(99) < 32'(rst_pct)) begin
        rst_n        = 1'b0;
        write_strobe = 1'b0;
        rst_cnt      = 2;
        #1;
        chk("async_rst_we", 32'(mem_write_enable), 32'd0);
        chk("async_rst_strobes", 32'(read_finished_strobes), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
      end
      write_strobe  = rst_n && ($urandom_range(99) < 32'(wr_pct));
      write_address = AW'($urandom);
      write_data    = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        if (served[i]) begin
          read_requests[i] = 1'b0;
          served[i]        = 1'b0;
        end else if (!read_requests[i] && $urandom_range(99) < 32'(req_pct)) begin
          read_requests[i]           = 1'b1;
          read_addresses[i*AW +: AW] = AW'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    write_strobe   = 1'b0;
    write_address  = '0;
    write_data     = '0;
    read_requests  = '0;
    read_addresses = '0;
    for (int i = 0; i < N; i++) served[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(400, 10, 20, 0);
    run(400, 100, 40, 0);
    run(300, 60, 30, 2);
    run(150, 0, 0, 0);
    chk("drain_reads", 32'(rq.size()), 32'd0);
    chk("drain_writes", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
